// File: rtl/stepdown_pkg.sv
// Shared types and helpers for the step-down converter PWM core.
// Used by both build variants (with and without STEPDOWN_SOFTSTART_EN).
package stepdown_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SS    = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Largest usable high-side on-time: leaves room for two dead-time gaps.
    function automatic int unsigned stepdown_maxd(input int unsigned period_w,
                                                  input int unsigned dead);
        return (32'd1 << period_w) - 2 * dead;
    endfunction

endpackage

// File: rtl/stepdown_deadtime_win.sv
// Window compares for the high-side and low-side enables.
// The low-side window sits DEAD cycles clear of both ends of the high-side pulse.
module stepdown_deadtime_win #(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DEAD     = 4
) (
    input  logic [PERIOD_W-1:0] cnt_i,
    input  logic [PERIOD_W-1:0] duty_eff_i,
    output logic                hs_win_o,
    output logic                ls_win_o
);

    localparam int unsigned LS_HI = (32'd1 << PERIOD_W) - 1 - DEAD;

    // One extra bit so duty_eff + DEAD cannot wrap into a false window.
    logic [PERIOD_W:0] ls_lo;

    assign ls_lo    = {1'b0, duty_eff_i} + (PERIOD_W+1)'(DEAD);
    assign hs_win_o = (cnt_i < duty_eff_i);
    assign ls_win_o = ({1'b0, cnt_i} >= ls_lo) &&
                      ({1'b0, cnt_i} <= (PERIOD_W+1)'(LS_HI));

endmodule

// File: rtl/stepdown_corestate_pwm.sv
// Step-down converter PWM core: OFF/SS/RUN/FAULT sequencing with dead-time.
// Optional soft-start ramp of the duty limit when STEPDOWN_SOFTSTART_EN is defined.
//   state | meaning
//   OFF   | idle, counter held at 0, both enables low
//   SS    | soft-start, duty capped by ramping limit (one cycle without macro)
//   RUN   | regulated PWM, power-good
//   FAULT | ocp/uvlo latched, waits for en=0 with faults clear
module stepdown_corestate_pwm
    import stepdown_pkg::*;
#(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DEAD     = 4
) (
    input  logic                CELCLK,
    input  logic                CELRST,
    input  logic                CELV,
    input  logic                CELG,
    input  logic                SUB,
    input  logic                en,
    input  logic [PERIOD_W-1:0] duty,
    input  logic                ocp,
    input  logic                uvlo,
    output logic                hs_on,
    output logic                ls_on,
    output logic [1:0]          state,
    output logic                run
);

    localparam int unsigned         MAXD     = stepdown_maxd(PERIOD_W, DEAD);
    localparam logic [PERIOD_W-1:0] MAXD_V   = PERIOD_W'(MAXD);
    localparam logic [PERIOD_W-1:0] CNT_LAST = '1;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] duty_q, duty_d, duty_eff;
    logic                hs_q, hs_d, ls_q, ls_d;
    logic                hs_win, ls_win;
    logic                active_q, active_d, wrap, fault_in;
    logic                unused_pins;

    assign unused_pins = ^{CELV, CELG, SUB};

    assign active_q = (state_q == ST_SS) || (state_q == ST_RUN);
    assign active_d = (state_d == ST_SS) || (state_d == ST_RUN);
    assign wrap     = active_q && (cnt_q == CNT_LAST);
    assign fault_in = ocp || uvlo;

`ifdef STEPDOWN_SOFTSTART_EN
    logic [PERIOD_W-1:0] lim_q, lim_d, duty_tmp;
    logic                lim_done;

    assign lim_done = wrap && (({1'b0, lim_q} + 1'b1) >= {1'b0, duty_q});

    // Limit keeps climbing (saturating) in RUN so later duty increases are also ramped.
    always_comb begin
        lim_d = lim_q;
        if (!active_q || !active_d) begin
            lim_d = '0;
        end else if (wrap && (lim_q != '1)) begin
            lim_d = lim_q + 1'b1;
        end
    end

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            lim_q <= '0;
        end else begin
            lim_q <= lim_d;
        end
    end
`endif

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (en && !fault_in) state_d = ST_SS;
            end
            ST_SS: begin
                if (fault_in) state_d = ST_FAULT;
                else if (!en) state_d = ST_OFF;
`ifdef STEPDOWN_SOFTSTART_EN
                else if (lim_done) state_d = ST_RUN;
`else
                else state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (fault_in) state_d = ST_FAULT;
                else if (!en) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (!en && !fault_in) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        state = state_q;
        run   = (state_q == ST_RUN);
    end

    // A new duty is taken at cnt==0 and used for that same cycle's compare.
    always_comb begin
        cnt_d  = (active_q && active_d) ? cnt_q + 1'b1 : '0;
        duty_d = (cnt_q == '0) ? duty : duty_q;
`ifdef STEPDOWN_SOFTSTART_EN
        duty_tmp = (duty_d < lim_q) ? duty_d : lim_q;
        duty_eff = (duty_tmp < MAXD_V) ? duty_tmp : MAXD_V;
`else
        duty_eff = (duty_d < MAXD_V) ? duty_d : MAXD_V;
`endif
        hs_d = active_q && active_d && hs_win;
        ls_d = active_q && active_d && ls_win;
    end

    stepdown_deadtime_win #(
        .PERIOD_W (PERIOD_W),
        .DEAD     (DEAD)
    ) u_win (
        .cnt_i      (cnt_q),
        .duty_eff_i (duty_eff),
        .hs_win_o   (hs_win),
        .ls_win_o   (ls_win)
    );

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            cnt_q  <= '0;
            duty_q <= '0;
            hs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            hs_q   <= hs_d;
            ls_q   <= ls_d;
        end
    end

    assign hs_on = hs_q;
    assign ls_on = ls_q;

endmodule

// File: tb/tb_stepdown_corestate_pwm.sv
// Directed bench for stepdown_corestate_pwm (PERIOD_W=8, DEAD=4).
// Soft-start checks run when STEPDOWN_SOFTSTART_EN is defined, PWM/fault checks otherwise.
module tb_stepdown_corestate_pwm;

    logic       CELCLK = 1'b0;
    logic       CELRST, CELV, CELG, SUB, en, ocp, uvlo;
    logic [7:0] duty;
    logic       hs_on, ls_on, run;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int hs_n, hs_last, ls_n, ls_first, ls_last, both, run0;

    always #5 CELCLK = ~CELCLK;

    stepdown_corestate_pwm #(.PERIOD_W(8), .DEAD(4)) dut (
        .CELCLK (CELCLK),
        .CELRST (CELRST),
        .CELV   (CELV),
        .CELG   (CELG),
        .SUB    (SUB),
        .en     (en),
        .duty   (duty),
        .ocp    (ocp),
        .uvlo   (uvlo),
        .hs_on  (hs_on),
        .ls_on  (ls_on),
        .state  (state),
        .run    (run)
    );

    task automatic tick();
        @(posedge CELCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Samples one full period; index i carries the enables defined by cnt == i.
    task automatic measure(input int chg_idx, input logic [7:0] chg_duty);
        hs_n = 0; ls_n = 0; hs_last = -1; ls_first = -1; ls_last = -1; both = 0;
        run0 = int'(run);
        for (int i = 0; i < 256; i++) begin
            if (hs_on === 1'b1) begin hs_n++; hs_last = i; end
            if (ls_on === 1'b1) begin
                ls_n++;
                if (ls_first < 0) ls_first = i;
                ls_last = i;
            end
            if (hs_on === 1'b1 && ls_on === 1'b1) both++;
            if (i == chg_idx) duty = chg_duty;
            tick();
        end
    endtask

    initial begin
        CELRST = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        en = 1'b0; ocp = 1'b0; uvlo = 1'b0; duty = 8'd0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_hs", hs_on, 0);
        chk("rst_ls", ls_on, 0);
        chk("rst_run", run, 0);

`ifdef STEPDOWN_SOFTSTART_EN
        CELRST = 1'b0; duty = 8'd3; en = 1'b1;
        tick();
        chk("ss_state", state, 1);
        tick();
        for (int p = 0; p < 4; p++) begin
            measure(-1, 8'd3);
            chk($sformatf("ss_hs_width_p%0d", p), hs_n, p);
            chk($sformatf("ss_run_p%0d", p), run0, (p == 3) ? 1 : 0);
            chk($sformatf("ss_overlap_p%0d", p), both, 0);
        end
`else
        CELRST = 1'b0; duty = 8'd64; en = 1'b1;
        tick();
        chk("ss_state", state, 1);
        chk("ss_run", run, 0);
        tick();
        chk("run_state", state, 2);
        chk("run_run", run, 1);

        measure(-1, 8'd0);
        chk("d64_hs_n", hs_n, 64);
        chk("d64_hs_last", hs_last, 63);
        chk("d64_ls_n", ls_n, 184);
        chk("d64_ls_first", ls_first, 68);
        chk("d64_ls_last", ls_last, 251);
        chk("d64_overlap", both, 0);

        measure(100, 8'd32);
        chk("midchg_hs_n", hs_n, 64);
        chk("midchg_ls_n", ls_n, 184);

        measure(-1, 8'd0);
        chk("d32_hs_n", hs_n, 32);
        chk("d32_hs_last", hs_last, 31);
        chk("d32_ls_n", ls_n, 216);
        chk("d32_ls_first", ls_first, 36);

        measure(0, 8'd255);
        chk("d32b_hs_n", hs_n, 32);

        measure(0, 8'd0);
        chk("d255_hs_n", hs_n, 248);
        chk("d255_hs_last", hs_last, 247);
        chk("d255_ls_n", ls_n, 0);
        chk("d255_ls_first", ls_first, -1);
        chk("d255_overlap", both, 0);

        measure(0, 8'd64);
        chk("d0_hs_n", hs_n, 0);
        chk("d0_ls_n", ls_n, 248);
        chk("d0_ls_first", ls_first, 4);
        chk("d0_ls_last", ls_last, 251);

        for (int i = 0; i < 10; i++) tick();
        chk("pre_ocp_hs", hs_on, 1);
        ocp = 1'b1;
        tick();
        chk("ocp_state", state, 3);
        chk("ocp_hs", hs_on, 0);
        chk("ocp_ls", ls_on, 0);
        chk("ocp_run", run, 0);
        ocp = 1'b0;
        tick(); tick();
        chk("fault_hold_en", state, 3);
        en = 1'b0; uvlo = 1'b1;
        tick();
        chk("fault_hold_uvlo", state, 3);
        uvlo = 1'b0;
        tick();
        chk("fault_exit", state, 0);

        en = 1'b1; uvlo = 1'b1;
        tick();
        chk("off_uvlo_block", state, 0);
        uvlo = 1'b0;
        tick();
        chk("off_to_ss", state, 1);
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("run_hs_on", hs_on, 1);
        en = 1'b0;
        tick();
        chk("en_off_state", state, 0);
        chk("en_off_hs", hs_on, 0);
        chk("en_off_run", run, 0);

        en = 1'b1;
        tick(); tick();
        for (int i = 0; i < 20; i++) tick();
        chk("prerst_hs", hs_on, 1);
        CELRST = 1'b1;
        tick();
        chk("midrst_state", state, 0);
        chk("midrst_hs", hs_on, 0);
        chk("midrst_ls", ls_on, 0);
        chk("midrst_run", run, 0);
        tick(); tick();
        CELRST = 1'b0;
        tick();
        chk("postrst_ss", state, 1);
        tick();
        uvlo = 1'b1;
        tick();
        chk("uvlo_over_en", state, 3);
        chk("uvlo_hs", hs_on, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepdown_corestate_pwm.md
STEPDOWN_CORESTATE_PWM -- requirements
Module: stepdown_corestate_pwm

Interface
REQ-001 Parameter: PERIOD_W, 8, period counter width; period = 2^PERIOD_W cycles.
REQ-002 Parameter: DEAD, 4, dead-time cycles inserted between high-side and low-side enables.
REQ-003 CELCLK  input  1  core clock.
REQ-004 CELRST  input  1  reset; one clock (CELCLK), reset synchronous and active-high.
REQ-005 CELV, CELG, SUB  input  1 each  supply/ground/substrate pins; no functional effect.
REQ-006 en  input  1  converter enable.
REQ-007 duty  input  PERIOD_W  requested high-side on-time in cycles.
REQ-008 ocp  input  1  overcurrent fault, synchronous to CELCLK.
REQ-009 uvlo  input  1  undervoltage lockout, synchronous to CELCLK.
REQ-010 hs_on  output  1  high-side enable; feeds downstream nand2 gate logic.
REQ-011 ls_on  output  1  low-side enable; feeds downstream nand2 gate logic.
REQ-012 state  output  2  current FSM state encoding.
REQ-013 run  output  1  high while state==RUN (power-good).

Function
REQ-014 FSM states SHALL be OFF=0, SS=1, RUN=2, FAULT=3.
REQ-015 OFF->SS when en=1 and uvlo=0 and ocp=0; period counter cnt held at 0 in OFF and FAULT.
REQ-016 cnt SHALL count 0..2^PERIOD_W-1 in SS/RUN, wrapping to 0.
REQ-017 duty SHALL be latched into duty_q only when cnt==0; mid-period changes take effect at the next wrap.
REQ-018 MAXD = 2^PERIOD_W - 2*DEAD; duty_eff = min(duty_q, duty_lim, MAXD).
REQ-019 hs_on SHALL be high for cnt in [0, duty_eff-1]; never high when duty_eff==0.
REQ-020 ls_on SHALL be high for cnt in [duty_eff+DEAD, 2^PERIOD_W-1-DEAD]; empty window gives ls_on=0 for the whole period.
REQ-021 hs_on and ls_on SHALL be registered, one cycle latency after the cnt value defining them, and never simultaneously high.
REQ-022 en=0 in SS or RUN -> OFF; both enables low on the next cycle.
REQ-023 ocp=1 or uvlo=1 in any state except OFF -> FAULT; both enables low on the next cycle; ocp or uvlo overrides en.
REQ-024 FAULT->OFF only when en=0, ocp=0 and uvlo=0 in the same cycle.
REQ-025 run SHALL be high only in RUN.

Reset
REQ-026 CELRST=1 SHALL force state=OFF, cnt=0, duty_q=0, duty_lim=0, hs_on=0, ls_on=0, run=0 on the next CELCLK edge.
REQ-027 Reset asserted mid-period SHALL take priority over all FSM transitions.

Configuration
REQ-028 Macro STEPDOWN_SOFTSTART_EN defined: in SS, duty_lim starts at 0 and increments by 1 at each cnt wrap; SS->RUN at the wrap where duty_lim reaches duty_q.
REQ-029 Macro undefined: SS lasts exactly one cycle (then RUN), duty_lim is absent and duty_eff = min(duty_q, MAXD).

Structure
REQ-030 Package stepdown_pkg SHALL hold the state enum and the MAXD computation function.
REQ-031 One sub-module, stepdown_deadtime_win, SHALL compute the hs/ls window compares from cnt, duty_eff and DEAD.

Verification
REQ-032 Reset: assert CELRST for 3 cycles mid-RUN -> hs_on=0, ls_on=0, state=0 and run=0 the cycle after the first reset edge.
REQ-033 Macro off, en=1, duty=64 -> each period shows hs_on high for 64 cycles, 4 cycles both low, ls_on high for cycles 68..251 (184 cycles), then 4 cycles both low.
REQ-034 duty=255 -> hs_on high for 248 cycles per period, ls_on never high.
REQ-035 ocp pulse at cnt=10 during hs_on -> hs_on=0 next cycle and state=3; remains in FAULT until en=0, then state=0.
REQ-036 Macro on, duty=3 -> hs_on widths 0, 1, 2, 3 over successive periods, with run asserting at the wrap where duty_lim reaches 3.
REQ-037 duty changed 64->32 at cnt=100 -> current period unchanged; next period hs_on high for 32 cycles.
